// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module   : alu_exec_unit
//  Purpose  : RV32 R-type integer execution unit with a valid/ready handshake
//             on both sides. Non-shift ops complete at the accept edge. A
//             shift by N>0 steps a work register one bit per cycle and
//             reaches DONE N edges after accept. At most one op is in flight.
//  Ports    : clock, reset       - rising-edge clock, async active-high reset
//             in_valid/in_ready  - operation offer / unit idle and accepting
//             funct7, funct3     - operation class / operation in class
//             rs1, rs2           - source operands (sampled only at accept)
//             out_valid/out_ready- result available / consumer takes result
//             result, illegal    - op result, unsupported funct7/funct3 flag
//  Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
  parameter logic [6:0] BASE  = 7'h00,
  parameter logic [6:0] EXTRA = 7'h20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  funct7,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        illegal
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] c_KIND_SLL = 2'd0;
  localparam logic [1:0] c_KIND_SRL = 2'd1;
  localparam logic [1:0] c_KIND_SRA = 2'd2;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_result;
  logic        r_illegal;
  logic [31:0] r_work;
  logic [4:0]  r_cnt;
  logic [1:0]  r_kind;

  logic        w_accept;
  logic        w_is_base;
  logic        w_is_extra;
  logic        w_legal;
  logic        w_is_shift;
  logic [1:0]  w_kind;
  logic [4:0]  w_shamt;
  logic        w_start_shift;
  logic [31:0] w_alu;
  logic [31:0] w_work_next;

  // in_ready is gated by reset so nothing can be offered as accepted while
  // reset is asserted, even though the state already reads IDLE.
  assign in_ready  = (r_state == IDLE) && !reset;
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign illegal   = r_illegal;

  assign w_accept   = in_valid && in_ready;
  assign w_is_base  = (funct7 == BASE);
  assign w_is_extra = (funct7 == EXTRA);
  assign w_shamt    = rs2[4:0];

  // Decode: legality, shift detection and shift kind.
  always_comb begin
    w_legal    = 1'b0;
    w_is_shift = 1'b0;
    w_kind     = c_KIND_SLL;
    if (w_is_base) begin
      w_legal = 1'b1;
      if (funct3 == 3'b001) begin
        w_is_shift = 1'b1;
        w_kind     = c_KIND_SLL;
      end else if (funct3 == 3'b101) begin
        w_is_shift = 1'b1;
        w_kind     = c_KIND_SRL;
      end
    end else if (w_is_extra) begin
      if (funct3 == 3'b000) begin
        w_legal = 1'b1;
      end else if (funct3 == 3'b101) begin
        w_legal    = 1'b1;
        w_is_shift = 1'b1;
        w_kind     = c_KIND_SRA;
      end
    end
  end

  assign w_start_shift = w_accept && w_legal && w_is_shift && (w_shamt != 5'd0);

  // Single-cycle results. Shifts land here only with shamt==0, where the
  // result is rs1 unchanged.
  always_comb begin
    w_alu = 32'h0;
    if (w_is_shift) begin
      w_alu = rs1;
    end else if (w_is_extra) begin
      w_alu = rs1 - rs2;
    end else begin
      case (funct3)
        3'b000:  w_alu = rs1 + rs2;
        3'b010:  w_alu = {31'h0, ($signed(rs1) < $signed(rs2))};
        3'b011:  w_alu = {31'h0, (rs1 < rs2)};
        3'b100:  w_alu = rs1 ^ rs2;
        3'b110:  w_alu = rs1 | rs2;
        3'b111:  w_alu = rs1 & rs2;
        default: w_alu = 32'h0;
      endcase
    end
  end

  // One-bit step of the iterative shifter. SRA replicates bit 31, which is
  // never changed by a right shift and so always holds the original sign.
  always_comb begin
    w_work_next = {r_work[30:0], 1'b0};
    case (r_kind)
      c_KIND_SRL: w_work_next = {1'b0, r_work[31:1]};
      c_KIND_SRA: w_work_next = {r_work[31], r_work[31:1]};
      default:    w_work_next = {r_work[30:0], 1'b0};
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic. DONE always returns to IDLE rather than accepting
  // directly, keeping a single op in flight.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = w_start_shift ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (r_cnt == 5'd1) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_result  <= 32'h0;
      r_illegal <= 1'b0;
      r_work    <= 32'h0;
      r_cnt     <= 5'd0;
      r_kind    <= c_KIND_SLL;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_illegal <= !w_legal;
            if (w_start_shift) begin
              r_work <= rs1;
              r_cnt  <= w_shamt;
              r_kind <= w_kind;
            end else begin
              r_result <= w_legal ? w_alu : 32'h0;
            end
          end
        end
        SHIFT: begin
          r_work <= w_work_next;
          r_cnt  <= r_cnt - 5'd1;
          if (r_cnt == 5'd1) begin
            r_result <= w_work_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_exec_unit
//  Purpose  : Self-checking bench for alu_exec_unit. Expected results come
//             from a behavioural model and pass through a scoreboard queue.
//             Latency is counted as clock edges after the accept edge at
//             which out_valid is first seen (0 for single-cycle ops, N for a
//             shift by N>0).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        illegal;

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_total;
  int   n_bad;

  alu_exec_unit #(.BASE(7'h00), .EXTRA(7'h20)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .funct7    (funct7),
    .funct3    (funct3),
    .rs1       (rs1),
    .rs2       (rs2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .illegal   (illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [6:0] f7, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [4:0] sh;
    sh    = b[4:0];
    e.res = 32'h0;
    e.ill = 1'b0;
    e.lat = 0;
    if (f7 == 7'h00) begin
      case (f3)
        3'd0: e.res = a + b;
        3'd1: begin e.res = a << sh; e.lat = int'(sh); end
        3'd2: e.res = ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
        3'd3: e.res = (a < b) ? 32'h1 : 32'h0;
        3'd4: e.res = a ^ b;
        3'd5: begin e.res = a >> sh; e.lat = int'(sh); end
        3'd6: e.res = a | b;
        default: e.res = a & b;
      endcase
    end else if (f7 == 7'h20 && f3 == 3'd0) begin
      e.res = a - b;
    end else if (f7 == 7'h20 && f3 == 3'd5) begin
      e.res = $unsigned($signed(a) >>> sh);
      e.lat = int'(sh);
    end else begin
      e.ill = 1'b1;
    end
    return e;
  endfunction

  // Offers one op, then either aborts it with reset abort_at edges after
  // accept, or waits for the result and holds out_ready low for hold cycles.
  task automatic run_op(input logic [6:0] f7, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input int hold, input int abort_at);
    exp_t e;
    exp_t got;
    int   edges;
    bit   busy_ready;
    bit   seen;
    logic [31:0] held;
    e = model(f7, f3, a, b);
    @(negedge clock);
    out_ready = (hold == 0);
    funct7    = f7;
    funct3    = f3;
    rs1       = a;
    rs2       = b;
    in_valid  = 1'b1;
    check("ready_idle", {31'h0, in_ready}, 32'h1);
    @(posedge clock);
    sb.push_back(e);
    #1;
    in_valid = 1'b0;
    funct7   = 7'($urandom);
    funct3   = 3'($urandom);
    rs1      = $urandom;
    rs2      = $urandom;

    if (abort_at >= 0) begin
      repeat (abort_at) @(posedge clock);
      #2 reset = 1'b1;
      #1;
      check("abort_out_valid", {31'h0, out_valid}, 32'h0);
      check("abort_in_ready", {31'h0, in_ready}, 32'h0);
      check("abort_result", result, 32'h0);
      got = sb.pop_back();
      @(negedge clock);
      reset = 1'b0;
      #1;
      check("ready_after_release", {31'h0, in_ready}, 32'h1);
      seen = 1'b0;
      repeat (40) begin
        @(posedge clock);
        #1;
        if (out_valid) seen = 1'b1;
      end
      check("no_ghost_result", {31'h0, seen}, 32'h0);
      return;
    end

    edges      = 0;
    busy_ready = 1'b0;
    while (!out_valid && edges < 200) begin
      if (in_ready) busy_ready = 1'b1;
      @(posedge clock);
      #1;
      edges++;
    end
    got = sb.pop_front();
    check("latency", 32'(edges), 32'(got.lat));
    check("busy_in_ready", {31'h0, busy_ready}, 32'h0);
    check("result", result, got.res);
    check("illegal", {31'h0, illegal}, {31'h0, got.ill});

    held = result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      in_valid = ~in_valid;
      @(posedge clock);
      #1;
      check("bp_out_valid", {31'h0, out_valid}, 32'h1);
      check("bp_result", result, held);
      check("bp_in_ready", {31'h0, in_ready}, 32'h0);
    end

    // Handoff edge with in_valid high: must not accept on this edge.
    @(negedge clock);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    check("handoff_out_valid", {31'h0, out_valid}, 32'h0);
    check("handoff_in_ready", {31'h0, in_ready}, 32'h1);
  endtask

  initial begin
    n_total   = 0;
    n_bad     = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    funct7    = 7'h0;
    funct3    = 3'h0;
    rs1       = 32'h0;
    rs2       = 32'h0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_in_ready", {31'h0, in_ready}, 32'h0);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_result", result, 32'h0);
    check("rst_illegal", {31'h0, illegal}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_release_ready", {31'h0, in_ready}, 32'h1);

    // Directed cases.
    run_op(7'h00, 3'b000, 32'd5, 32'd7, 0, -1);                 // ADD
    run_op(7'h20, 3'b000, 32'd3, 32'd5, 0, -1);                 // SUB wrap
    run_op(7'h00, 3'b010, 32'd3, 32'd5, 0, -1);                 // SLT
    run_op(7'h00, 3'b011, 32'hFFFF_FFFF, 32'd1, 0, -1);         // SLTU
    run_op(7'h00, 3'b010, 32'hFFFF_FFFF, 32'd1, 0, -1);         // SLT signed
    run_op(7'h20, 3'b101, 32'h8000_0000, 32'd4, 0, -1);         // SRA
    run_op(7'h00, 3'b001, 32'd1, 32'h25, 0, -1);                // SLL masked
    run_op(7'h00, 3'b001, 32'd1, 32'h20, 0, -1);                // SLL shamt 0
    run_op(7'h00, 3'b101, 32'h8000_0000, 32'd1, 0, -1);         // SRL by 1
    run_op(7'h00, 3'b101, 32'hF0F0_0000, 32'd31, 0, -1);        // SRL by 31
    run_op(7'h00, 3'b110, 32'h1234_0000, 32'h0000_5678, 3, -1); // OR + backpressure
    run_op(7'h01, 3'b000, 32'd9, 32'd9, 3, -1);                 // illegal funct7
    run_op(7'h20, 3'b001, 32'd9, 32'd9, 0, -1);                 // illegal funct3
    run_op(7'h00, 3'b001, 32'hDEAD_BEEF, 32'd31, 0, 2);         // reset mid-shift
    run_op(7'h00, 3'b000, 32'hFFFF_FFFF, 32'd2, 0, -1);         // ADD after reset

    // Random mix across all classes.
    for (int i = 0; i < 24; i++) begin
      logic [6:0] f7;
      case ($urandom_range(0, 3))
        0:       f7 = 7'h00;
        1:       f7 = 7'h20;
        2:       f7 = 7'h00;
        default: f7 = 7'($urandom);
      endcase
      run_op(f7, 3'($urandom), $urandom, $urandom, int'($urandom_range(0, 2)), -1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
